// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (start 0, 8 data bits LSB first, stop 1, idle high).
// The line is synchronized, the start bit is re-checked at the sample point,
// every data and stop bit is sampled once per bit period at SAMPLE_PT, and
// each good byte is delivered with a valid/ack handshake. Framing errors and
// overruns are reported as one-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,                    // clk cycles per serial bit (>= 1)
    parameter int SAMPLE_PT    = (CLKS_PER_BIT - 1) / 2 // sample cycle within a bit period
) (
    input  logic       clk,
    input  logic       reset,       // asynchronous, active low
    input  logic       rx_in,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               SINGLE_CLK = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic [1:0]       sync;      // sync[0] may go metastable, sync[1] is clean
    logic             rx_s;
    logic [CNT_W-1:0] cnt;       // cycle position within the current bit period
    logic [2:0]       bit_idx;   // data bit being received, 0..7
    logic [7:0]       shreg;     // data bits arrive LSB first, shifted in from the top

    assign rx_s = sync[1];

    // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make each flop capture the value its
            // predecessor held before this edge, which is what forms the two stages.
            sync <= {sync[0], rx_in};
        end
    end

    // Receive state machine with registered handshake and error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses unless re-asserted below.
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // NOTE: a new byte delivered later in this block overrides this clear,
            // because the last non-blocking assignment to a signal wins; that gives
            // "simultaneous ack and new byte keeps data_valid high" for free.
            if (data_ack) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // This cycle is T0 when the line is low; it is position 0 of
                    // the start bit, so SAMPLE_PT=0 needs no further check.
                    if (!rx_s) begin
                        busy <= 1'b1;
                        if (SINGLE_CLK) begin
                            state <= DATA;
                        end else begin
                            state <= START;
                            cnt   <= CNT_ONE;
                        end
                    end
                end

                START: begin
                    // A line that is high again at the sample point was a glitch.
                    if (cnt == CNT_SAMPLE && rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == CNT_SAMPLE) begin
                        shreg <= {rx_s, shreg[7:1]};
                    end
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    // Act on the stop sample immediately so IDLE can catch a
                    // start bit that follows with no gap.
                    if (cnt == CNT_SAMPLE) begin
                        busy <= 1'b0;
                        cnt  <= '0;
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            overrun    <= data_valid && !data_ack;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line (break) must not re-trigger a start.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. One receiver runs at one clk per
// bit (matching uart_tx loopback timing), a second at 16 clks per bit with
// the sample point at cycle 7.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx1, ack1, dv1, fe1, ov1, busy1;
    logic [7:0] dout1;
    logic       rx16, ack16, dv16, fe16, ov16, busy16;
    logic [7:0] dout16;

    int errors = 0;
    int checks = 0;

    // Pulse counters: each counts clk cycles in which the flag was high.
    int fe1_n  = 0;
    int ov1_n  = 0;
    int fe16_n = 0;
    int ov16_n = 0;

    uart_rx #(.CLKS_PER_BIT(1)) u_rx1 (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx1),
        .data_ack   (ack1),
        .data_out   (dout1),
        .data_valid (dv1),
        .frame_err  (fe1),
        .overrun    (ov1),
        .busy       (busy1)
    );

    uart_rx #(.CLKS_PER_BIT(16), .SAMPLE_PT(7)) u_rx16 (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx16),
        .data_ack   (ack16),
        .data_out   (dout16),
        .data_valid (dv16),
        .frame_err  (fe16),
        .overrun    (ov16),
        .busy       (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of the error pulses on both receivers.
    always @(posedge clk) begin
        if (fe1 === 1'b1)  fe1_n  <= fe1_n + 1;
        if (ov1 === 1'b1)  ov1_n  <= ov1_n + 1;
        if (fe16 === 1'b1) fe16_n <= fe16_n + 1;
        if (ov16 === 1'b1) ov16_n <= ov16_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One-clk-per-bit frame, as uart_tx would send it; line left high.
    task automatic send1(input logic [7:0] b);
        rx1 = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            rx1 = b[k];
            tick();
        end
        rx1 = 1'b1;
        tick();
    endtask

    // Sixteen-clk-per-bit frame with a chosen stop value; line left at stop value.
    task automatic send16(input logic [7:0] b, input logic stop_bit);
        rx16 = 1'b0;
        tick(16);
        for (int k = 0; k < 8; k++) begin
            rx16 = b[k];
            tick(16);
        end
        rx16 = stop_bit;
        tick(16);
    endtask

    // Sixteen-clk-per-bit frame where each data bit is correct only in the one
    // cycle (k+1)*16+7 after the start edge and inverted everywhere else, so the
    // byte is recovered only if every sample lands on that exact cycle.
    // Returns 152 cycles after the start edge with the line high.
    task automatic send16_narrow(input logic [7:0] b);
        for (int t = 0; t < 152; t++) begin
            int   k;
            logic v;
            if (t < 16) begin
                rx16 = 1'b0;
            end else if (t < 144) begin
                k    = (t - 16) / 16;
                v    = b[k];
                rx16 = (t == (k + 1) * 16 + 7) ? v : ~v;
            end else begin
                rx16 = 1'b1;
            end
            tick();
        end
    endtask

    task automatic wait_dv(input bit on16, input int budget, input string tag);
        int n = 0;
        while (((on16 ? dv16 : dv1) !== 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(on16 ? dv16 : dv1), 1);
    endtask

    initial begin
        int fe_base;
        int ov_base;

        reset = 1'b0;
        rx1   = 1'b1;
        rx16  = 1'b1;
        ack1  = 1'b0;
        ack16 = 1'b0;
        tick(3);

        // Reset values on both receivers.
        check("rst_dout1",  32'(dout1),  0);
        check("rst_dv1",    32'(dv1),    0);
        check("rst_fe1",    32'(fe1),    0);
        check("rst_ov1",    32'(ov1),    0);
        check("rst_busy1",  32'(busy1),  0);
        check("rst_dout16", 32'(dout16), 0);
        check("rst_dv16",   32'(dv16),   0);
        check("rst_busy16", 32'(busy16), 0);
        reset = 1'b1;
        tick(4);

        // Loopback-style frame 0xA5: start edge at cycle 0, stop sampled at
        // cycle 11 (two synchronizer cycles later), byte visible at cycle 12.
        send1(8'hA5);
        tick();
        check("a5_dv_early", 32'(dv1),   0);
        check("a5_busy",     32'(busy1), 1);
        tick();
        check("a5_dv",       32'(dv1),   1);
        check("a5_dout",     32'(dout1), 'hA5);
        check("a5_busy_off", 32'(busy1), 0);
        check("a5_no_err",   32'(fe1_n + ov1_n), 0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("a5_ack_clr",  32'(dv1),   0);
        check("a5_hold",     32'(dout1), 'hA5);
        tick(3);

        // Back-to-back 0x3C then 0xC3, acknowledging the first mid-way through
        // the second frame.
        send1(8'h3C);
        fork
            send1(8'hC3);
            begin
                tick(2);
                check("b2b_dv1st",   32'(dv1),   1);
                check("b2b_dout1st", 32'(dout1), 'h3C);
                ack1 = 1'b1;
                tick();
                ack1 = 1'b0;
                check("b2b_ack1st",  32'(dv1),   0);
            end
        join
        tick(2);
        check("b2b_dv2nd",   32'(dv1),   1);
        check("b2b_dout2nd", 32'(dout1), 'hC3);
        check("b2b_no_err",  32'(fe1_n + ov1_n), 0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        tick(3);

        // Overrun: 0x11 left unacknowledged, then 0x22 completes.
        send1(8'h11);
        tick(3);
        check("ovr_dv_11",   32'(dv1),   1);
        check("ovr_dout_11", 32'(dout1), 'h11);
        ov_base = ov1_n;
        send1(8'h22);
        tick(2);
        check("ovr_pulse",   32'(ov1),   1);
        check("ovr_dout_22", 32'(dout1), 'h22);
        check("ovr_dv_22",   32'(dv1),   1);
        tick();
        check("ovr_one_cyc", 32'(ov1_n - ov_base), 1);

        // Same situation but data_ack coincides with the completing stop sample.
        send1(8'h33);
        tick();
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("ack_cmp_dv",   32'(dv1),   1);
        check("ack_cmp_dout", 32'(dout1), 'h33);
        check("ack_cmp_ov",   32'(ov1),   0);
        tick();
        check("ack_cmp_dv2",  32'(dv1),   1);
        check("ack_cmp_ovn",  32'(ov1_n - ov_base), 1);

        // 16 clks/bit, 0x5A with each bit valid only at its sample instant.
        send16_narrow(8'h5A);
        check("s16_dv_early", 32'(dv16),   0);
        check("s16_busy",     32'(busy16), 1);
        tick(2);
        check("s16_dv",       32'(dv16),   1);
        check("s16_dout",     32'(dout16), 'h5A);
        check("s16_busy_off", 32'(busy16), 0);
        check("s16_no_err",   32'(fe16_n + ov16_n), 0);

        // Three-cycle low glitch on the idle line: rejected at the start check.
        rx16 = 1'b0;
        tick(3);
        rx16 = 1'b1;
        tick();
        check("glitch_busy",     32'(busy16), 1);
        tick(20);
        check("glitch_busy_off", 32'(busy16), 0);
        check("glitch_dv",       32'(dv16),   1);
        check("glitch_dout",     32'(dout16), 'h5A);
        check("glitch_no_err",   32'(fe16_n + ov16_n), 0);

        // 0x81 with a low stop bit, then the line held low for 40 bit times.
        fe_base = fe16_n;
        send16(8'h81, 1'b0);
        tick(40 * 16);
        rx16 = 1'b1;
        tick(40);
        check("brk_one_fe",   32'(fe16_n - fe_base), 1);
        check("brk_dv",       32'(dv16),   1);
        check("brk_dout",     32'(dout16), 'h5A);
        check("brk_busy",     32'(busy16), 0);
        ack16 = 1'b1;
        tick();
        ack16 = 1'b0;
        check("brk_ack_clr",  32'(dv16),   0);

        // Line high again: 0x42 must be received cleanly.
        send16(8'h42, 1'b1);
        wait_dv(1'b1, 64, "rec_dv");
        check("rec_dout",     32'(dout16), 'h42);
        check("rec_no_err",   32'(fe16_n - fe_base + ov16_n), 1);

        // Reset asserted in the middle of the data bits of 0xFF.
        rx1 = 1'b0;
        tick();
        rx1 = 1'b1;
        tick(4);
        check("mid_busy",    32'(busy1), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_dout",  32'(dout1),  0);
        check("mid_rst_dv",    32'(dv1),    0);
        check("mid_rst_busy",  32'(busy1),  0);
        check("mid_rst_fe",    32'(fe1),    0);
        check("mid_rst_ov",    32'(ov1),    0);
        check("mid_rst_dv16",  32'(dv16),   0);
        tick(2);
        reset = 1'b1;
        tick(12);
        check("post_rst_idle", 32'(dv1 | busy1), 0);

        send1(8'h0F);
        wait_dv(1'b0, 20, "post_rst_dv");
        check("post_rst_dout", 32'(dout1), 'h0F);
        check("fe1_never",     32'(fe1_n), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
